f2_ibuff: RTL and testbench

- Fetch-stage instruction line buffer that sits directly upstream of decode stage 1.
- Issues sequential 64-byte line requests to the I-cache and queues the returned lines.
- Tracks the architectural fetch PC at halfword granularity and presents one (possibly stitched) 512-bit line plus the PC to D1 for byte rotation.
- Handles resteers from the ROB, the branch unit and D1, compressed/uncompressed PC advance, and instructions that cross line boundaries.

---
 rtl/f2_ibuff_if.sv | 44 ++++
 rtl/f2_ibuff.sv | 153 +++++++++++++++
 tb/tb_f2_ibuff.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/f2_ibuff_if.sv
// Port bundle for the fetch instruction buffer: I-cache request/response,
// resteer inputs from ROB/BR/D1, and the line presented to decode stage 1.
interface f2_ibuff_if #(
  parameter int XLEN    = 32,
  parameter int EPOCH_W = 3
);
  logic               fetch_req;
  logic [XLEN-1:0]    fetch_addr;
  logic [EPOCH_W-1:0] fetch_epoch;
  logic               fetch_gnt;
  logic               line_valid;
  logic [511:0]       line_data;
  logic [EPOCH_W-1:0] line_epoch;
  logic               line_exception;
  logic               resteer_ROB;
  logic [XLEN-1:0]    resteer_target_ROB;
  logic               resteer_BR;
  logic [XLEN-1:0]    resteer_target_BR;
  logic               resteer_D1;
  logic [XLEN-1:0]    resteer_target_D1;
  logic               d1_ready;
  logic               ibuff_valid;
  logic [511:0]       IBuff_out;
  logic [XLEN-1:0]    pc_out;
  logic               exception_out;

  // Buffer side
  modport master (
    output fetch_req, fetch_addr, fetch_epoch,
    output ibuff_valid, IBuff_out, pc_out, exception_out,
    input  fetch_gnt, line_valid, line_data, line_epoch, line_exception,
    input  resteer_ROB, resteer_target_ROB, resteer_BR, resteer_target_BR,
    input  resteer_D1, resteer_target_D1, d1_ready
  );

  // I-cache / pipeline side
  modport slave (
    input  fetch_req, fetch_addr, fetch_epoch,
    input  ibuff_valid, IBuff_out, pc_out, exception_out,
    output fetch_gnt, line_valid, line_data, line_epoch, line_exception,
    output resteer_ROB, resteer_target_ROB, resteer_BR, resteer_target_BR,
    output resteer_D1, resteer_target_D1, d1_ready
  );
endinterface

// File: rtl/f2_ibuff.sv
// Fetch-stage instruction line buffer. Issues sequential 64B line requests
// under a credit limit, queues epoch-matching responses, tracks the fetch PC
// at halfword granularity and stitches the next line's first halfword in
// when a 32-bit instruction straddles a line boundary.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_RUN  | normal fetch: requests issued, instructions presented
//   ST_HALT | a faulting line was consumed; no requests, nothing presented
//           | until the next resteer
module f2_ibuff #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter int              EPOCH_W  = 3,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic        clk,
  input logic        rst,
  f2_ibuff_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t             state, state_nxt;
  logic [XLEN-1:0]    pc, pc_nxt, pc_adv;
  logic [XLEN-1:0]    faddr, faddr_nxt;
  logic [EPOCH_W-1:0] epoch, epoch_nxt;
  logic [PTR_W-1:0]   rd_ptr, rd_ptr_nxt, wr_ptr, wr_ptr_nxt, rd_ptr_p1;
  logic [CNT_W-1:0]   count, count_nxt, outst, outst_nxt;
  logic [CNT_W:0]     occ;

  logic [511:0]       q_data [DEPTH];
  logic [DEPTH-1:0]   q_exc;

  logic               resteer_any;
  logic [XLEN-1:0]    tgt;
  logic [511:0]       head_line, stitched;
  logic               head_exc, head_present, second_present;
  logic [5:0]         s;
  logic               compressed, crossing, exc_raw, valid_int;
  logic               consume, push, pop, req, fire;

  // Resteer arbitration: ROB over BR over D1
  always_comb begin
    resteer_any = bus.resteer_ROB | bus.resteer_BR | bus.resteer_D1;
    if (bus.resteer_ROB)     tgt = bus.resteer_target_ROB;
    else if (bus.resteer_BR) tgt = bus.resteer_target_BR;
    else                     tgt = bus.resteer_target_D1;
  end

  assign rd_ptr_p1      = rd_ptr + PTR_W'(1);
  assign head_line      = q_data[rd_ptr];
  assign head_exc       = q_exc[rd_ptr];
  assign head_present   = (count != '0);
  assign second_present = (count >= CNT_W'(2));
  assign s              = pc[5:0];
  // Byte at offset s sits at bit 8*(63-s); its two low bits decide the length.
  assign compressed     = (head_line[{~s, 3'b000} +: 2] != 2'b11);
  assign crossing       = (s == 6'd62) && !compressed;
  assign exc_raw        = head_exc | (crossing & second_present & q_exc[rd_ptr_p1]);
  assign valid_int      = head_present && !resteer_any && (state == ST_RUN) &&
                          (!crossing || second_present || head_exc);
  assign stitched       = crossing ? {q_data[rd_ptr_p1][511:496], head_line[495:0]}
                                   : head_line;

  assign consume = valid_int && bus.d1_ready;
  assign push    = bus.line_valid && (bus.line_epoch == epoch);
  assign occ     = {1'b0, count} + {1'b0, outst};
  assign req     = !rst && (state == ST_RUN) && (occ < DEPTH_C);
  assign fire    = req && bus.fetch_gnt;
  assign pc_adv  = pc + (compressed ? XLEN'(2) : XLEN'(4));

  // Next-state: resteer flush overrides consume, request and response bookkeeping
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    faddr_nxt  = faddr;
    epoch_nxt  = epoch;
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    count_nxt  = count;
    outst_nxt  = outst;
    pop        = 1'b0;
    if (resteer_any) begin
      state_nxt  = ST_RUN;
      pc_nxt     = tgt & ~XLEN'(1);
      faddr_nxt  = tgt & ~XLEN'(63);
      epoch_nxt  = epoch + EPOCH_W'(1);
      rd_ptr_nxt = '0;
      wr_ptr_nxt = '0;
      count_nxt  = '0;
      outst_nxt  = '0;
    end else begin
      if (consume) begin
        if (exc_raw) begin
          state_nxt = ST_HALT;
        end else begin
          pc_nxt = pc_adv;
          pop    = (pc_adv[XLEN-1:6] != pc[XLEN-1:6]);
        end
      end
      if (fire) faddr_nxt = faddr + XLEN'(64);
      if (push) wr_ptr_nxt = wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr_nxt = rd_ptr + PTR_W'(1);
      count_nxt = count + CNT_W'(push) - CNT_W'(pop);
      outst_nxt = outst + CNT_W'(fire) - CNT_W'(push);
    end
  end

  // State and pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_RUN;
      pc     <= RESET_PC;
      faddr  <= RESET_PC & ~XLEN'(63);
      epoch  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      outst  <= '0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      faddr  <= faddr_nxt;
      epoch  <= epoch_nxt;
      rd_ptr <= rd_ptr_nxt;
      wr_ptr <= wr_ptr_nxt;
      count  <= count_nxt;
      outst  <= outst_nxt;
    end
  end

  // Line storage; contents are only observed through count-qualified pointers
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= bus.line_data;
      q_exc[wr_ptr]  <= bus.line_exception;
    end
  end

  assign bus.fetch_req     = req;
  assign bus.fetch_addr    = faddr;
  assign bus.fetch_epoch   = epoch;
  assign bus.ibuff_valid   = valid_int;
  assign bus.IBuff_out     = valid_int ? stitched : '0;
  assign bus.pc_out        = pc;
  assign bus.exception_out = valid_int & exc_raw;

endmodule

// File: tb/tb_f2_ibuff.sv
// Directed bench for f2_ibuff: a cycle table for the fill/stream phase, then
// hand-written sequences for compressed advance, line crossing, resteer
// priority with stale responses, and exception halt/restart.
module tb_f2_ibuff;
  localparam int XLEN = 32;
  localparam int EPOCH_W = 3;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  f2_ibuff_if #(.XLEN(XLEN), .EPOCH_W(EPOCH_W)) bus();

  f2_ibuff #(.XLEN(XLEN), .DEPTH(DEPTH), .EPOCH_W(EPOCH_W), .RESET_PC(32'h1000)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        gnt;
    logic        lv;
    int          lsel;
    logic        rdy;
    logic        req;
    logic [31:0] faddr;
    logic        ivalid;
    logic [31:0] pc;
    int          eline;
  } vec_t;

  vec_t         tbl[$];
  logic [511:0] lines [8];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] mk_line(input logic [5:0] tag, input logic c0);
    logic [511:0] l;
    logic [7:0] b;
    l = '0;
    for (int a = 0; a < 64; a++) begin
      if (a % 2 == 0) b = {tag, 2'b11};
      else            b = {6'(a), 2'b00};
      if (c0 && a == 0) b = {tag, 2'b01};
      l[8*(63-a) +: 8] = b;
    end
    return l;
  endfunction

  function automatic vec_t v(input logic gnt, input logic lv, input int lsel, input logic rdy,
                             input logic req, input logic [31:0] faddr, input logic ivalid,
                             input logic [31:0] pc, input int eline);
    vec_t r;
    r.gnt = gnt; r.lv = lv; r.lsel = lsel; r.rdy = rdy;
    r.req = req; r.faddr = faddr; r.ivalid = ivalid; r.pc = pc; r.eline = eline;
    return r;
  endfunction

  task automatic idle();
    bus.fetch_gnt          = 1'b0;
    bus.line_valid         = 1'b0;
    bus.line_data          = '0;
    bus.line_epoch         = '0;
    bus.line_exception     = 1'b0;
    bus.resteer_ROB        = 1'b0;
    bus.resteer_target_ROB = '0;
    bus.resteer_BR         = 1'b0;
    bus.resteer_target_BR  = '0;
    bus.resteer_D1         = 1'b0;
    bus.resteer_target_D1  = '0;
    bus.d1_ready           = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] exp_line;
    lines[0] = mk_line(6'd1, 1'b0);
    lines[1] = mk_line(6'd2, 1'b0);
    lines[2] = mk_line(6'd3, 1'b1);
    lines[3] = mk_line(6'd4, 1'b0);
    lines[4] = mk_line(6'd5, 1'b0);
    lines[5] = mk_line(6'd6, 1'b0);
    lines[6] = mk_line(6'd7, 1'b0);
    lines[7] = '0;

    // Fill with four grants, two responses, then stream line A with d1_ready held
    tbl.push_back(v(1, 0, 0, 0, 1, 32'h1000, 0, 32'h1000, -1));
    tbl.push_back(v(1, 0, 0, 0, 1, 32'h1040, 0, 32'h1000, -1));
    tbl.push_back(v(1, 0, 0, 0, 1, 32'h1080, 0, 32'h1000, -1));
    tbl.push_back(v(1, 0, 0, 0, 1, 32'h10C0, 0, 32'h1000, -1));
    tbl.push_back(v(0, 1, 0, 0, 0, 32'h1100, 0, 32'h1000, -1));
    tbl.push_back(v(0, 1, 1, 0, 0, 32'h1100, 1, 32'h1000, 0));
    for (int k = 0; k < 16; k++)
      tbl.push_back(v(0, 0, 0, 1, 0, 32'h1100, 1, 32'h1000 + 32'(4*k), 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 32'h1100, 1, 32'h1040, 1));

    rst = 1'b1;
    idle();
    @(negedge clk);
    #1;
    chk("rst fetch_req", bus.fetch_req, 0);
    chk("rst fetch_addr", bus.fetch_addr, 32'h1000);
    chk("rst fetch_epoch", bus.fetch_epoch, 0);
    chk("rst pc_out", bus.pc_out, 32'h1000);
    chk("rst ibuff_valid", bus.ibuff_valid, 0);
    chk("rst IBuff_out", bus.IBuff_out, 0);
    chk("rst exception_out", bus.exception_out, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      idle();
      bus.fetch_gnt  = tbl[i].gnt;
      bus.line_valid = tbl[i].lv;
      bus.line_data  = lines[tbl[i].lsel];
      bus.d1_ready   = tbl[i].rdy;
      #1;
      exp_line = (tbl[i].eline < 0) ? 512'd0 : lines[tbl[i].eline];
      chk($sformatf("vec%0d fetch_req", i), bus.fetch_req, tbl[i].req);
      chk($sformatf("vec%0d fetch_addr", i), bus.fetch_addr, tbl[i].faddr);
      chk($sformatf("vec%0d ibuff_valid", i), bus.ibuff_valid, tbl[i].ivalid);
      chk($sformatf("vec%0d pc_out", i), bus.pc_out, tbl[i].pc);
      chk($sformatf("vec%0d IBuff_out", i), bus.IBuff_out, exp_line);
      chk($sformatf("vec%0d exception_out", i), bus.exception_out, 0);
    end

    // Compressed then 32-bit advance after a ROB resteer; stale response dropped
    @(negedge clk); idle();
    bus.resteer_ROB = 1; bus.resteer_target_ROB = 32'h1000; bus.d1_ready = 1;
    #1; chk("rob ivalid same cycle", bus.ibuff_valid, 0);
    @(negedge clk); idle(); bus.fetch_gnt = 1;
    #1;
    chk("rob ivalid next cycle", bus.ibuff_valid, 0);
    chk("rob fetch_req", bus.fetch_req, 1);
    chk("rob fetch_addr", bus.fetch_addr, 32'h1000);
    chk("rob fetch_epoch", bus.fetch_epoch, 1);
    chk("rob pc_out", bus.pc_out, 32'h1000);
    @(negedge clk); idle();
    bus.line_valid = 1; bus.line_data = lines[0]; bus.line_epoch = 0;
    @(negedge clk); idle();
    bus.line_valid = 1; bus.line_data = lines[2]; bus.line_epoch = 1;
    #1; chk("stale epoch0 dropped", bus.ibuff_valid, 0);
    @(negedge clk); idle(); bus.d1_ready = 1;
    #1;
    chk("cmp ivalid", bus.ibuff_valid, 1);
    chk("cmp pc 1000", bus.pc_out, 32'h1000);
    chk("cmp IBuff_out", bus.IBuff_out, lines[2]);
    @(negedge clk); idle(); bus.d1_ready = 1;
    #1; chk("cmp pc 1002", bus.pc_out, 32'h1002);
    @(negedge clk); idle();
    #1;
    chk("cmp pc 1006", bus.pc_out, 32'h1006);
    chk("cmp ivalid after", bus.ibuff_valid, 1);

    // Line-crossing 32-bit instruction at 0x103E
    @(negedge clk); idle();
    bus.resteer_ROB = 1; bus.resteer_target_ROB = 32'h103E;
    #1; chk("cross resteer ivalid", bus.ibuff_valid, 0);
    @(negedge clk); idle(); bus.fetch_gnt = 1;
    #1;
    chk("cross fetch_addr0", bus.fetch_addr, 32'h1000);
    chk("cross pc", bus.pc_out, 32'h103E);
    @(negedge clk); idle(); bus.fetch_gnt = 1;
    #1; chk("cross fetch_addr1", bus.fetch_addr, 32'h1040);
    @(negedge clk); idle();
    bus.line_valid = 1; bus.line_data = lines[3]; bus.line_epoch = 2;
    @(negedge clk); idle(); bus.d1_ready = 1;
    #1; chk("cross one line ivalid", bus.ibuff_valid, 0);
    @(negedge clk); idle();
    bus.line_valid = 1; bus.line_data = lines[4]; bus.line_epoch = 2;
    #1; chk("cross still waiting", bus.ibuff_valid, 0);
    @(negedge clk); idle(); bus.d1_ready = 1;
    #1;
    chk("cross ivalid", bus.ibuff_valid, 1);
    chk("cross pc_out", bus.pc_out, 32'h103E);
    exp_line = lines[3];
    exp_line[511:496] = lines[4][511:496];
    chk("cross stitched", bus.IBuff_out, exp_line);
    chk("cross exception_out", bus.exception_out, 0);
    @(negedge clk); idle(); bus.fetch_gnt = 1;
    #1;
    chk("cross pc after", bus.pc_out, 32'h1042);
    chk("cross next head valid", bus.ibuff_valid, 1);
    chk("cross next head line", bus.IBuff_out, lines[4]);
    chk("cross fetch_req", bus.fetch_req, 1);
    chk("cross fetch_addr2", bus.fetch_addr, 32'h1080);

    // BR and D1 together: BR wins; in-flight old-epoch line is dropped
    @(negedge clk); idle();
    bus.resteer_BR = 1; bus.resteer_target_BR = 32'h2006;
    bus.resteer_D1 = 1; bus.resteer_target_D1 = 32'h3000;
    bus.d1_ready = 1;
    #1; chk("br ivalid same cycle", bus.ibuff_valid, 0);
    @(negedge clk); idle();
    bus.line_valid = 1; bus.line_data = lines[6]; bus.line_epoch = 2;
    #1;
    chk("br pc_out", bus.pc_out, 32'h2006);
    chk("br fetch_addr", bus.fetch_addr, 32'h2000);
    chk("br fetch_epoch", bus.fetch_epoch, 3);
    chk("br ivalid next cycle", bus.ibuff_valid, 0);
    @(negedge clk); idle();
    #1; chk("br stale dropped", bus.ibuff_valid, 0);

    // Faulting line halts until a ROB resteer restarts fetch
    @(negedge clk); idle(); bus.fetch_gnt = 1;
    #1;
    chk("exc fetch_req", bus.fetch_req, 1);
    chk("exc fetch_addr", bus.fetch_addr, 32'h2000);
    @(negedge clk); idle();
    bus.line_valid = 1; bus.line_data = lines[5]; bus.line_epoch = 3; bus.line_exception = 1;
    @(negedge clk); idle(); bus.d1_ready = 1;
    #1;
    chk("exc ivalid", bus.ibuff_valid, 1);
    chk("exc exception_out", bus.exception_out, 1);
    chk("exc pc_out", bus.pc_out, 32'h2006);
    @(negedge clk); idle(); bus.d1_ready = 1;
    #1;
    chk("halt ivalid", bus.ibuff_valid, 0);
    chk("halt fetch_req", bus.fetch_req, 0);
    chk("halt exception_out", bus.exception_out, 0);
    @(negedge clk); idle(); bus.fetch_gnt = 1;
    #1;
    chk("halt fetch_req later", bus.fetch_req, 0);
    chk("halt ivalid later", bus.ibuff_valid, 0);
    @(negedge clk); idle();
    bus.resteer_ROB = 1; bus.resteer_target_ROB = 32'h4000;
    #1; chk("restart ivalid same cycle", bus.ibuff_valid, 0);
    @(negedge clk); idle(); bus.fetch_gnt = 1;
    #1;
    chk("restart fetch_req", bus.fetch_req, 1);
    chk("restart fetch_addr", bus.fetch_addr, 32'h4000);
    chk("restart fetch_epoch", bus.fetch_epoch, 4);
    chk("restart pc_out", bus.pc_out, 32'h4000);
    @(negedge clk); idle();
    bus.line_valid = 1; bus.line_data = lines[6]; bus.line_epoch = 4;
    @(negedge clk); idle();
    #1;
    chk("restart ivalid", bus.ibuff_valid, 1);
    chk("restart pc", bus.pc_out, 32'h4000);
    chk("restart exception_out", bus.exception_out, 0);
    chk("restart IBuff_out", bus.IBuff_out, lines[6]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
